synchronous_fifo: RTL and testbench
===================================

SYNCHRONOUS_FIFO -- requirements
Module: synchronous_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 Parameter DEPTH, default 16, number of storage entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-high reset; the name is kept for bench compatibility and the polarity is high.
REQ-005 data_in  input  DATA_WIDTH  write data.
REQ-006 wr_en  input  1  write request.
REQ-007 rd_en  input  1  read request.
REQ-008 data_out  output  DATA_WIDTH  registered read data.
REQ-009 full  output  1  high when DEPTH entries are stored.
REQ-010 empty  output  1  high when 0 entries are stored.

Function
REQ-011 A write SHALL be accepted on a rising edge when wr_en=1 and full=0; data_in is stored at the write pointer, and the write pointer advances by 1.
REQ-012 A read SHALL be accepted on a rising edge when rd_en=1 and empty=0; the word at the read pointer is loaded into data_out at that edge (1-cycle latency), and the read pointer advances by 1.
REQ-013 data_out SHALL hold its last value when no read is accepted, including a read attempted while empty.
REQ-014 A write while full SHALL be dropped, with no state change; a read while empty SHALL be ignored.
REQ-015 Acceptance SHALL be decided from the pre-edge full/empty values; when both rd_en and wr_en are accepted in the same cycle, occupancy is unchanged.
REQ-016 Write with read while full: the read is accepted, the write is dropped, and full deasserts next cycle.
REQ-017 Write with read while empty: the write is accepted, the read is ignored, and empty deasserts next cycle.
REQ-018 Pointers SHALL be log2(DEPTH)+1 bits wide, with the extra MSB used as a wrap bit, and SHALL wrap modulo 2*DEPTH.
REQ-019 empty SHALL equal (wr_ptr == rd_ptr).
REQ-020 full SHALL be asserted when the pointer MSBs differ and the lower bits are equal.
REQ-021 full and empty SHALL be derived combinationally from the registered pointers and SHALL never both be 1.
REQ-022 FIFO order SHALL be preserved across any number of pointer wraps.

Reset
REQ-023 While rst_n=1 at a rising edge, the block SHALL set: wr_ptr=0, rd_ptr=0, data_out=0, empty=1, full=0.
REQ-024 Reset SHALL take priority over wr_en and rd_en in the same cycle.
REQ-025 A reset during operation SHALL discard all stored contents.
REQ-026 Storage memory SHALL NOT be reset.

Configuration
REQ-027 Macro SYNC_FIFO_COUNT_EN, when defined, SHALL add an output port count, of width log2(DEPTH)+1, equal to wr_ptr - rd_ptr (range 0..DEPTH) and reset to 0.
REQ-028 Without SYNC_FIFO_COUNT_EN, the count port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package fifo_pkg SHALL hold DEFAULT_DATA_WIDTH=8, DEFAULT_DEPTH=16, and a function clog2-based PTR_W helper.
REQ-030 Storage SHALL be a sub-module fifo_mem: 1 write port, 1 synchronous read port, no reset, sized DEPTH x DATA_WIDTH.
REQ-031 Pointer and flag logic SHALL reside in synchronous_fifo.

Verification
REQ-032 Bench SHALL cover: reset -> empty=1, full=0, data_out=0; then with rd_en=1 for 1 cycle -> data_out stays 0 and empty stays 1.
REQ-033 Bench SHALL cover: write 0x11..0x20 (16 words) -> full=1 after the 16th edge; a 17th write of 0xFF is dropped.
REQ-034 Bench SHALL cover: read 16 words from the full FIFO -> data_out sequence 0x11..0x20, each valid 1 edge after its read; empty=1 after the last read.
REQ-035 Bench SHALL cover: continuous write+read of 40 words (beyond 2 wraps) with DEPTH=16 -> output order matches input, with no full/empty glitch.
REQ-036 Bench SHALL cover: FIFO full with wr_en=1 and rd_en=1 -> data_out = oldest word and count 16->15; FIFO empty with both -> write accepted and count 0->1.
REQ-037 Bench SHALL cover: fill 5 words, assert rst_n for 1 edge -> empty=1, count=0; the next write/read returns the new data only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-width helper for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH      = 16;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one write port, one registered read port, no reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : fifo_mem

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with wrap-bit pointers and combinational full/empty.
// Optional occupancy output enabled by defining SYNC_FIFO_COUNT_EN.
module synchronous_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
`ifdef SYNC_FIFO_COUNT_EN
  output logic [$clog2(DEPTH):0]  count,
`endif
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_W  = ptr_w(DEPTH);
  localparam int unsigned ADDR_W = PTR_W - 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  out_clr_q, out_clr_d;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags come straight from the registered pointers.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    out_clr_d = out_clr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      out_clr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      out_clr_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      out_clr_q <= out_clr_d;
    end
  end

  // Writes and reads are gated by reset so it wins over both requests.
  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc && !rst_n),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (data_in),
    .re_i    (rd_acc && !rst_n),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  // The unreset read register is masked until the first read after reset.
  assign data_out = out_clr_q ? '0 : mem_rdata;

`ifdef SYNC_FIFO_COUNT_EN
  assign count = wr_ptr_q - rd_ptr_q;
`endif

endmodule : synchronous_fifo

// File: tb/tb_synchronous_fifo.sv
// Directed self-checking bench for synchronous_fifo (DEPTH=16, DATA_WIDTH=8).
module tb_synchronous_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
`ifdef SYNC_FIFO_COUNT_EN
  logic [4:0]    count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  synchronous_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_out (data_out),
`ifdef SYNC_FIFO_COUNT_EN
    .count    (count),
`endif
    .full     (full),
    .empty    (empty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef SYNC_FIFO_COUNT_EN
    chk(tag, 32'(count), 32'(exp));
`endif
  endtask

  // Advance one edge; inputs settle and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b1;
    data_in = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk_cnt("rst_count", 0);

    // Read while empty is ignored.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("rd_empty_dout", 32'(data_out), 0);
    chk("rd_empty_flag", 32'(empty), 1);

    // Fill with 0x11..0x20.
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = DW'(8'h11 + i);
      step();
      chk("fill_full", 32'(full), (i == 15) ? 1 : 0);
      chk("fill_empty", 32'(empty), 0);
    end
    data_in = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("ovf_full", 32'(full), 1);
    chk_cnt("ovf_count", 16);

    // Drain; 0xFF must not appear.
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("drain_dout", 32'(data_out), 32'(8'h11 + i));
      chk("drain_empty", 32'(empty), (i == 15) ? 1 : 0);
    end
    rd_en = 1'b0;
    step();
    chk("drain_hold", 32'(data_out), 32'h20);

    // Write+read while empty: write only.
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 8'h5A;
    step();
    rd_en = 1'b0;
    chk("both_empty_flag", 32'(empty), 0);
    chk("both_empty_dout", 32'(data_out), 32'h20);
    chk_cnt("both_empty_count", 1);
    for (int i = 0; i < 15; i++) begin
      data_in = DW'(8'h60 + i);
      step();
    end
    chk("refill_full", 32'(full), 1);

    // Write+read while full: read only.
    rd_en   = 1'b1;
    data_in = 8'hAA;
    step();
    wr_en = 1'b0;
    chk("both_full_dout", 32'(data_out), 32'h5A);
    chk("both_full_flag", 32'(full), 0);
    chk_cnt("both_full_count", 15);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("refill_dout", 32'(data_out), 32'(8'h60 + i));
    end
    rd_en = 1'b0;
    chk("refill_empty", 32'(empty), 1);

    // Stream 40 words through at occupancy 1, crossing several wraps.
    wr_en   = 1'b1;
    data_in = 8'h80;
    step();
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data_in = DW'(8'h81 + i);
      step();
      chk("stream_dout", 32'(data_out), 32'(8'h80 + i));
      chk("stream_empty", 32'(empty), 0);
      chk("stream_full", 32'(full), 0);
    end
    wr_en = 1'b0;
    step();
    rd_en = 1'b0;
    chk("stream_last", 32'(data_out), 32'hA8);
    chk("stream_done", 32'(empty), 1);

    // Reset mid-operation discards contents and beats concurrent requests.
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = DW'(8'h31 + i);
      step();
    end
    chk_cnt("pre_rst_count", 5);
    rst_n   = 1'b1;
    rd_en   = 1'b1;
    data_in = 8'hEE;
    step();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_full", 32'(full), 0);
    chk("mid_rst_dout", 32'(data_out), 0);
    chk_cnt("mid_rst_count", 0);
    wr_en   = 1'b1;
    data_in = 8'h99;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    chk("post_rst_dout", 32'(data_out), 32'h99);
    chk("post_rst_empty", 32'(empty), 1);
    step();
    rd_en = 1'b0;
    chk("post_rst_hold", 32'(data_out), 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_synchronous_fifo
